// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped UART transmitter with a small transmit FIFO.
//
// The CPU writes a byte to the data register at BASE. Each byte is queued in a
// circular FIFO and then sent as one frame: a start bit, 8 data bits LSB first,
// and a stop bit. Every bit is held for CLKS_PER_BIT clocks. When the FIFO still
// holds data at the end of a stop bit, the next frame starts at once, so frames
// run back to back with no idle time between them. The status register sits at
// BASE+1. Writing that address clears the sticky overflow flag.
//
// Ports:
//   clock     system clock; all state changes on its rising edge
//   reset     asynchronous, active-high reset
//   address   CPU bus address
//   write_en  CPU bus write strobe
//   data_in   CPU write data
//   data_out  status read data {4'b0, ovf, busy, empty, full}; 8'h00 when not selected
//   tx        serial line, idle high
//   busy      high while a frame is shifting or the FIFO is non-empty
module uart_tx_port #(
    parameter logic [15:0] BASE         = 16'hf010,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned DEPTH        = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address,
    input  logic        write_en,
    input  logic [7:0]  data_in,
    output logic [7:0]  data_out,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned PtrW       = $clog2(DEPTH);
    localparam int unsigned CntW       = PtrW + 1;
    localparam logic [7:0]  BaudLast   = 8'(CLKS_PER_BIT - 1);
    localparam logic [15:0] StatusAddr = BASE + 16'd1;
    localparam logic [CntW-1:0] CountFull = CntW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]      fifo_mem [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q, count_d;
    logic            ovf_q;

    logic full, empty, wr_req, enq, deq, ovf_clr;

    assign full    = (count_q == CountFull);
    assign empty   = (count_q == '0);
    assign wr_req  = write_en && (address == BASE);
    assign ovf_clr = write_en && (address == StatusAddr);
    // A write into a full FIFO still fits if the shifter frees a slot on the same edge.
    assign enq     = wr_req && (!full || deq);

    always_comb begin
        count_d = count_q;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (enq) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (deq) rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
            if (ovf_clr) begin
                ovf_q <= 1'b0;
            end else if (wr_req && !enq) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the count and pointers define what is valid.
    always_ff @(posedge clock) begin
        if (enq) fifo_mem[wr_ptr_q] <= data_in;
    end

    // ------------------------------------------------------------------
    // Shifter
    // ------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [7:0] baud_q, baud_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic       baud_end;

    assign baud_end = (baud_q == BaudLast);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 8'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        deq     = 1'b0;
        case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!empty) begin
                    deq     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!empty) begin
                        deq     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        tx = 1'b1;
        case (state_q)
            StStart: tx = 1'b0;
            StData:  tx = shift_q[0];
            default: tx = 1'b1;
        endcase
    end

    assign busy     = (state_q != StIdle) || !empty;
    assign data_out = (address == StatusAddr && !write_en) ?
                      {4'b0000, ovf_q, busy, empty, full} : 8'h00;

endmodule

// File: tb/tb_uart_tx_port.sv
module tb_uart_tx_port;

    localparam int C = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        tx;
    logic        busy;

    always #5 clock = ~clock;

    uart_tx_port #(
        .BASE         (16'hf010),
        .CLKS_PER_BIT (C),
        .DEPTH        (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .address  (address),
        .write_en (write_en),
        .data_in  (data_in),
        .data_out (data_out),
        .tx       (tx),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serial line receiver: samples each bit mid-way, records frame start cycles.
    logic [7:0] rx_q [$];
    int         start_q [$];
    int         frame_err = 0;
    int         cyc = 0;

    initial begin : monitor
        int         rx_cnt;
        logic [7:0] sh;
        rx_cnt = 0;
        sh     = 8'h00;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                rx_cnt = 0;
            end else if (rx_cnt == 0) begin
                if (tx == 1'b0) begin
                    rx_cnt = 1;
                    start_q.push_back(cyc);
                end
            end else begin
                rx_cnt++;
                if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2) sh = {tx, sh[7:1]};
                if (rx_cnt == 38 && tx !== 1'b1) frame_err++;
                if (rx_cnt == 40) begin
                    rx_q.push_back(sh);
                    rx_cnt = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    logic [7:0] exp_b [6];
    logic [9:0] frame;

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clock);
        address  = a;
        data_in  = d;
        write_en = 1'b1;
        @(posedge clock);
        #1;
        write_en = 1'b0;
        address  = 16'h0000;
        data_in  = 8'h00;
    endtask

    task automatic read_status(input string tag, input logic [7:0] exp);
        address  = 16'hf011;
        write_en = 1'b0;
        #1;
        check_eq(tag, data_out, exp);
        address = 16'h0000;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while (busy && n < max) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_eq(tag, busy, 0);
    endtask

    task automatic check_rx(input string tag, input int n);
        check_eq({tag, " count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) check_eq($sformatf("%s byte%0d", tag, i), rx_q[i], exp_b[i]);
        end
        for (int i = 0; i < n - 1; i++) begin
            if (i + 1 < start_q.size())
                check_eq($sformatf("%s gap%0d", tag, i), start_q[i+1] - start_q[i], 10 * C);
        end
        check_eq({tag, " framing"}, frame_err, 0);
        rx_q.delete();
        start_q.delete();
        frame_err = 0;
    endtask

    initial begin : main
        int lows;
        reset    = 1'b1;
        address  = 16'h0000;
        write_en = 1'b0;
        data_in  = 8'h00;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset tx", tx, 1);
        check_eq("reset busy", busy, 0);
        read_status("reset status", 8'h02);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_eq("post-reset tx", tx, 1);
        check_eq("post-reset busy", busy, 0);

        // Status decode when idle
        read_status("idle status", 8'h02);
        address = 16'hf012;
        #1;
        check_eq("f012 read", data_out, 8'h00);
        address = 16'hf010;
        #1;
        check_eq("f010 read", data_out, 8'h00);
        address = 16'h0000;

        // Single byte, checked clock by clock
        frame = {1'b1, 8'h41, 1'b0};
        bus_write(16'hf010, 8'h41);
        read_status("status after write", 8'h04);
        for (int i = 0; i < 10 * C; i++) begin
            @(posedge clock);
            #1;
            check_eq($sformatf("single tx clk%0d", i), tx, frame[i/C]);
        end
        @(posedge clock);
        #1;
        check_eq("single busy end", busy, 0);
        exp_b[0] = 8'h41;
        check_rx("single", 1);

        // Back-to-back frames
        bus_write(16'hf010, 8'h48);
        bus_write(16'hf010, 8'h69);
        repeat (79) @(posedge clock);
        #1;
        check_eq("b2b busy clk80", busy, 1);
        @(posedge clock);
        #1;
        check_eq("b2b busy clk81", busy, 0);
        exp_b[0] = 8'h48;
        exp_b[1] = 8'h69;
        check_rx("b2b", 2);

        // Overflow: six writes, the sixth dropped
        for (int i = 0; i < 6; i++) bus_write(16'hf010, 8'(8'h11 * (i + 1)));
        read_status("ovf status", 8'h0D);
        bus_write(16'hf011, 8'h00);
        address = 16'hf011;
        #1;
        check_eq("ovf cleared", data_out[3], 0);
        address = 16'h0000;
        wait_idle("ovf idle", 500);
        for (int i = 0; i < 5; i++) exp_b[i] = 8'(8'h11 * (i + 1));
        check_rx("ovf", 5);
        read_status("ovf final status", 8'h02);

        // Reset during DATA bit 3 (0xA5 has bit3 = 0)
        bus_write(16'hf010, 8'hA5);
        bus_write(16'hf010, 8'h5A);
        repeat (17) @(posedge clock);
        #1;
        check_eq("bit3 tx low", tx, 0);
        reset = 1'b1;
        #1;
        check_eq("mid-frame reset tx", tx, 1);
        check_eq("mid-frame reset busy", busy, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clock);
            #1;
            if (tx !== 1'b1) lows++;
        end
        check_eq("after reset tx idle", lows, 0);
        read_status("after reset status", 8'h02);
        rx_q.delete();
        start_q.delete();
        frame_err = 0;

        // Full FIFO written on the same edge the shifter dequeues
        for (int i = 0; i < 5; i++) bus_write(16'hf010, 8'(8'hC1 + i));
        read_status("full status", 8'h05);
        repeat (4 * C + 5 * C + C - 4) @(posedge clock);
        bus_write(16'hf010, 8'hC6);
        read_status("full+deq status", 8'h05);
        wait_idle("full+deq idle", 500);
        for (int i = 0; i < 6; i++) exp_b[i] = 8'(8'hC1 + i);
        check_rx("full+deq", 6);
        read_status("full+deq final status", 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
